// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter with leading-zero blanking and overflow
// indication, framed by a start/busy/done handshake.
module bin_to_bcd_converter #(
  parameter int unsigned WIDTH    = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig_thou,
  output logic [3:0]       dig_hund,
  output logic [3:0]       dig_tens,
  output logic [3:0]       dig_ones
);

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  localparam int unsigned     CntW      = $clog2(WIDTH + 1);
  localparam int unsigned     CmpW      = (WIDTH > 14) ? WIDTH : 14;
  localparam logic [CntW-1:0] LastCnt   = CntW'(WIDTH - 1);
  localparam logic [15:0]     RstDigits = BLANK_LZ ? 16'hFFF0 : 16'h0000;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [15:0]      digits_q, digits_d;
  logic [15:0]      adj;
  logic [15:0]      shifted;

  // Overflow forces all-blank; otherwise blank zero digits above the first non-zero one.
  function automatic logic [15:0] map_digits(input logic [15:0] bcd, input logic ovf_in);
    logic [15:0] res;
    logic        b3, b2, b1;
    res = bcd;
    b3  = (bcd[15:12] == 4'd0);
    b2  = b3 && (bcd[11:8] == 4'd0);
    b1  = b2 && (bcd[7:4] == 4'd0);
    if (ovf_in) begin
      res = 16'hFFFF;
    end else if (BLANK_LZ) begin
      if (b3) res[15:12] = 4'hF;
      if (b2) res[11:8]  = 4'hF;
      if (b1) res[7:4]   = 4'hF;
    end
    return res;
  endfunction

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    // Bits leaving the thousands nibble are dropped; ovf covers that range.
    shifted = 16'({adj, sr_q[WIDTH-1]});
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sr_d       = bin_in;
          scratch_d  = 16'd0;
          cnt_d      = '0;
          ovf_pend_d = CmpW'(bin_in) > CmpW'(9999);
          state_d    = StConvert;
        end
      end
      StConvert: begin
        sr_d      = sr_q << 1;
        scratch_d = shifted;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          digits_d = map_digits(shifted, ovf_pend_q);
          ovf_d    = ovf_pend_q;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      scratch_q  <= 16'd0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= RstDigits;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
    end
  end

  assign busy     = (state_q == StConvert);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign dig_thou = digits_q[15:12];
  assign dig_hund = digits_q[11:8];
  assign dig_tens = digits_q[7:4];
  assign dig_ones = digits_q[3:0];

endmodule
